data_mem_arbiter: RTL and testbench

Shares port 1 (144-bit read/write) of the dataMemory block between two requesters: requester 0 is the vector load/store unit and requester 1 is the loader/debug DMA.
Uses round-robin arbitration with an optional bus lock for multi-word sequences. It tracks in-flight reads and routes each read result back to the requester that issued it.
Port 2 of dataMemory (16-bit read-only) is not arbitrated.

---
 rtl/data_mem_pkg.sv | 13 +
 rtl/rd_tag_pipe.sv | 33 +++
 rtl/data_mem_arbiter.sv | 104 ++++++++++
 tb/tb_data_mem_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared widths and types for the dataMemory port-1 arbiter.
package data_mem_pkg;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 144;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
    typedef logic req_id_t;
    typedef struct packed {
        logic              we;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage shift register carrying {valid, id} of accepted reads.
module rd_tag_pipe
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid_i,
    input  req_id_t in_id_i,
    output logic    out_valid_o,
    output req_id_t out_id_o
);
    logic [DEPTH-1:0]    valid_q;
    req_id_t [DEPTH-1:0] id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q[0] <= in_valid_i;
            id_q[0]    <= in_id_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_id_o    = id_q[DEPTH-1];
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin, lockable arbiter for dataMemory port 1 with read-return routing.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    req_id_t           prio_q, prio_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    mem_req_t          req0, req1, sel;
    logic              g0, g1, xfer, own_req, tag_valid;
    req_id_t           tag_id;

    assign req0 = {r0_we, r0_lock, r0_addr, r0_wdata};
    assign req1 = {r1_we, r1_lock, r1_addr, r1_wdata};

    // In IDLE prio only breaks ties; an owner is granted exclusively.
    assign g0 = !rst && r0_req && (state_q == OWN0 || (state_q == IDLE && (!r1_req || prio_q == 1'b0)));
    assign g1 = !rst && r1_req && (state_q == OWN1 || (state_q == IDLE && (!r0_req || prio_q == 1'b1)));
    assign xfer    = g0 || g1;
    assign sel     = g1 ? req1 : (g0 ? req0 : mem_req_t'(0));
    assign own_req = (state_q == OWN1) ? r1_req : r0_req;

    assign r0_gnt    = g0;
    assign r1_gnt    = g1;
    assign mem_we    = xfer && sel.we;
    assign mem_addr  = sel.addr;
    assign mem_wdata = sel.wdata;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        tmo_d   = '0;
        if (state_q == IDLE) begin
            if (xfer && r0_req && r1_req) prio_d = g0;
            if (xfer && sel.lock) state_d = g1 ? OWN1 : OWN0;
        end else begin
            tmo_d = own_req ? '0 : tmo_q + 1'b1;
            if ((xfer && !sel.lock) || (!own_req && tmo_q == TW'(LOCK_TIMEOUT - 1))) begin
                state_d = IDLE;
                prio_d  = (state_q == OWN0);
                tmo_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            tmo_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            tmo_q   <= tmo_d;
            if (r0_rvalid) rdata0_q <= mem_rdata;
            if (r1_rvalid) rdata1_q <= mem_rdata;
        end
    end

    rd_tag_pipe #(.DEPTH(READ_LATENCY)) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (xfer && !sel.we),
        .in_id_i    (g1),
        .out_valid_o(tag_valid),
        .out_id_o   (tag_id)
    );

    // Read data is passed through on the return cycle and held afterwards.
    assign r0_rvalid = tag_valid && (tag_id == 1'b0);
    assign r1_rvalid = tag_valid && (tag_id == 1'b1);
    assign r0_rdata  = r0_rvalid ? mem_rdata : rdata0_q;
    assign r1_rdata  = r1_rvalid ? mem_rdata : rdata1_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of arbitration, locking, timeout and read routing.
module tb_data_mem_arbiter;
    import data_mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              r0_req = 1'b0, r0_we = 1'b0, r0_lock = 1'b0;
    logic [ADDR_W-1:0] r0_addr = '0;
    logic [DATA_W-1:0] r0_wdata = '0;
    logic              r1_req = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
    logic [ADDR_W-1:0] r1_addr = '0;
    logic [DATA_W-1:0] r1_wdata = '0;
    logic              r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, mem_we;
    logic [DATA_W-1:0] r0_rdata, r1_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem [int];
    int                checks = 0;
    int                errors = 0;

    data_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read memory; unwritten word a reads as 2*a+1.
    always @(posedge clk) begin
        mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : DATA_W'(2 * int'(mem_addr) + 1);
        if (mem_we) mem[int'(mem_addr)] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 20'd9; r0_wdata = 144'd9;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 20'd8; r1_wdata = 144'd8;
        tick;
        #1;
        chk("rst_r0_gnt", r0_gnt, 0);
        chk("rst_r1_gnt", r1_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_r0_rvalid", r0_rvalid, 0);
        chk("rst_r1_rdata", r1_rdata, 0);
        // reset mid-read
        tick;
        rst = 1'b0; r0_we = 1'b0; r0_addr = 20'd30; r1_req = 1'b0;
        #1 chk("midrd_gnt", r0_gnt, 1);
        tick;
        rst = 1'b1;
        #1;
        chk("midrd_rvalid_in_rst", r0_rvalid, 0);
        chk("midrd_rdata_in_rst", r0_rdata, 0);
        chk("midrd_gnt_in_rst", r0_gnt, 0);
        chk("midrd_addr_in_rst", mem_addr, 0);
        r0_req = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        #1 chk("midrd_no_rvalid_a", r0_rvalid, 0);
        tick;
        chk("midrd_no_rvalid_b", r0_rvalid, 0);
        // contention from reset: prio starts at r0
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 20'd10;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 20'd20;
        #1;
        chk("cont_c0_r0_gnt", r0_gnt, 1);
        chk("cont_c0_r1_gnt", r1_gnt, 0);
        chk("cont_c0_addr", mem_addr, 10);
        tick;
        #1;
        chk("cont_c1_r1_gnt", r1_gnt, 1);
        chk("cont_c1_r0_gnt", r0_gnt, 0);
        chk("cont_c1_addr", mem_addr, 20);
        chk("cont_c1_r0_rvalid", r0_rvalid, 1);
        chk("cont_c1_r0_rdata", r0_rdata, 21);
        chk("cont_c1_r1_rvalid", r1_rvalid, 0);
        tick;
        #1;
        chk("cont_c2_r0_gnt", r0_gnt, 1);
        chk("cont_c2_r1_rvalid", r1_rvalid, 1);
        chk("cont_c2_r1_rdata", r1_rdata, 41);
        chk("cont_c2_r0_rvalid", r0_rvalid, 0);
        chk("cont_c2_r0_hold", r0_rdata, 21);
        tick;
        #1;
        chk("cont_c3_r1_gnt", r1_gnt, 1);
        chk("cont_c3_r0_rvalid", r0_rvalid, 1);
        tick;
        r0_req = 1'b0; r1_req = 1'b0;
        #1;
        chk("cont_c4_r1_rvalid", r1_rvalid, 1);
        chk("cont_c4_r1_rdata", r1_rdata, 41);
        chk("cont_c4_r0_rvalid", r0_rvalid, 0);
        // single write then read-after-write
        tick;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 20'd5000; r0_wdata = 144'd255;
        #1;
        chk("wr_gnt", r0_gnt, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 5000);
        chk("wr_mem_wdata", mem_wdata, 255);
        tick;
        r0_we = 1'b0;
        #1;
        chk("rd_gnt", r0_gnt, 1);
        chk("rd_mem_we", mem_we, 0);
        tick;
        r0_req = 1'b0;
        #1;
        chk("raw_rvalid", r0_rvalid, 1);
        chk("raw_rdata", r0_rdata, 255);
        chk("raw_mem_we", mem_we, 0);
        tick;
        chk("raw_rvalid_pulse", r0_rvalid, 0);
        chk("raw_rdata_hold", r0_rdata, 255);
        // lock: r0 wins first tie, then r1 holds bus for 3 writes
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 20'd200; r0_wdata = 144'hAA; r0_lock = 1'b0;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 20'd300; r1_wdata = 144'd1; r1_lock = 1'b1;
        #1;
        chk("lk_pre_r0_gnt", r0_gnt, 1);
        chk("lk_pre_r1_gnt", r1_gnt, 0);
        tick;
        r0_we = 1'b0; r0_addr = 20'd7;
        #1;
        chk("lk_w1_r1_gnt", r1_gnt, 1);
        chk("lk_w1_r0_gnt", r0_gnt, 0);
        chk("lk_w1_addr", mem_addr, 300);
        chk("lk_w1_we", mem_we, 1);
        tick;
        r1_addr = 20'd301; r1_wdata = 144'd2;
        #1;
        chk("lk_w2_r1_gnt", r1_gnt, 1);
        chk("lk_w2_r0_gnt", r0_gnt, 0);
        tick;
        r1_addr = 20'd302; r1_lock = 1'b0;
        #1;
        chk("lk_w3_r1_gnt", r1_gnt, 1);
        chk("lk_w3_r0_gnt", r0_gnt, 0);
        tick;
        r1_addr = 20'd303;
        #1;
        chk("lk_rel_r0_gnt", r0_gnt, 1);
        chk("lk_rel_r1_gnt", r1_gnt, 0);
        chk("lk_rel_addr", mem_addr, 7);
        tick;
        r0_req = 1'b0;
        #1;
        chk("lk_after_r1_gnt", r1_gnt, 1);
        chk("lk_after_r0_rvalid", r0_rvalid, 1);
        chk("lk_after_r0_rdata", r0_rdata, 15);
        tick;
        r1_req = 1'b0;
        // lock timeout
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 20'd400; r0_wdata = 144'd5; r0_lock = 1'b1;
        #1 chk("to_lock_gnt", r0_gnt, 1);
        tick;
        r0_req = 1'b0; r0_lock = 1'b0;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 20'd500;
        for (int i = 1; i <= 15; i++) begin
            #1 chk($sformatf("to_idle%0d_r1_gnt", i), r1_gnt, 0);
            tick;
        end
        #1 chk("to_release_r1_gnt", r1_gnt, 1);
        tick;
        // back-to-back reads by r1
        r1_we = 1'b0; r1_addr = 20'd1;
        #1 chk("b2b_1_gnt", r1_gnt, 1);
        for (int a = 2; a <= 4; a++) begin
            tick;
            r1_addr = ADDR_W'(a);
            #1;
            chk($sformatf("b2b_%0d_gnt", a), r1_gnt, 1);
            chk($sformatf("b2b_%0d_rvalid", a), r1_rvalid, 1);
            chk($sformatf("b2b_%0d_rdata", a), r1_rdata, DATA_W'(2 * (a - 1) + 1));
            chk($sformatf("b2b_%0d_r0_rvalid", a), r0_rvalid, 0);
        end
        tick;
        r1_req = 1'b0;
        #1;
        chk("b2b_last_rvalid", r1_rvalid, 1);
        chk("b2b_last_rdata", r1_rdata, 9);
        chk("b2b_last_r0_rvalid", r0_rvalid, 0);
        tick;
        chk("b2b_end_rvalid", r1_rvalid, 0);
        chk("b2b_end_r0_rvalid", r0_rvalid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
